// File: rtl/fmap_stream_buffer_if.sv
// Pixel stream and two-cycle synchronous read port of the feature-map buffer.
// The master side is the conv stream and next-layer reader; the slave side is the buffer.
interface fmap_stream_buffer_if #(
  parameter int unsigned ADDR_W = 14
);
  logic signed [31:0]  in_data;
  logic                in_valid;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          rd_data;

  modport master (output in_data, in_valid, rd_addr, input rd_data);
  modport slave  (input in_data, in_valid, rd_addr, output rd_data);
endinterface

// File: rtl/fmap_stream_buffer.sv
// Feature-map buffer: saturates a conv output stream to 8 bits, stores it linearly,
// and serves reads with address-registered / data-registered timing.
module fmap_stream_buffer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned HEIGHT  = 32,
  parameter int unsigned FILTERS = 16,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  fmap_stream_buffer_if.slave   bus,
  output logic [ADDR_W:0]       wr_count,
  output logic                  plane_done,
  output logic                  full,
  output logic                  overrun
);

  localparam int unsigned PLANE  = WIDTH * HEIGHT;
  localparam int unsigned DEPTH  = PLANE * FILTERS;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PIX_W  = (PLANE > 1) ? $clog2(PLANE) : 1;

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W + 1)'(DEPTH);
  localparam logic [PIX_W-1:0]  PLANE_LAST = PIX_W'(PLANE - 1);

  typedef enum logic {
    S_FILL,
    S_FULL
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [PIX_W-1:0]    pix;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [7:0]          sat;
  logic                we;
  logic [7:0]          mem [DEPTH];

  always_comb begin
    sat = bus.in_data[7:0];
    if (bus.in_data < 0)
      sat = '0;
    else if (bus.in_data > 32'sd255)
      sat = '1;
  end

  // clear outranks a same-cycle sample; nothing is written while reset is held
  assign we = !rst && !clear && bus.in_valid && (state == S_FILL);

  // RAM is deliberately unreset; the read in the control block sees pre-edge contents
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr[MEM_AW-1:0]] <= sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FILL;
      wr_ptr      <= '0;
      pix         <= '0;
      wr_count    <= '0;
      plane_done  <= 1'b0;
      full        <= 1'b0;
      overrun     <= 1'b0;
      rd_addr_q   <= '0;
      bus.rd_data <= '0;
    end else begin
      rd_addr_q <= bus.rd_addr;
      if ({1'b0, rd_addr_q} < DEPTH_W)
        bus.rd_data <= mem[rd_addr_q[MEM_AW-1:0]];
      else
        bus.rd_data <= '0;

      plane_done <= 1'b0;
      if (clear) begin
        state    <= S_FILL;
        wr_ptr   <= '0;
        pix      <= '0;
        wr_count <= '0;
        full     <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        case (state)
          S_FILL: begin
            if (bus.in_valid) begin
              wr_ptr   <= wr_ptr + ADDR_W'(1);
              wr_count <= wr_count + (ADDR_W + 1)'(1);
              if (pix == PLANE_LAST) begin
                pix        <= '0;
                plane_done <= 1'b1;
              end else begin
                pix <= pix + PIX_W'(1);
              end
              if (wr_ptr == LAST_PTR) begin
                state <= S_FULL;
                full  <= 1'b1;
              end
            end
          end
          S_FULL: begin
            if (bus.in_valid)
              overrun <= 1'b1;
          end
          default: state <= S_FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fmap_stream_buffer.sv
// Randomized self-checking bench for fmap_stream_buffer against an array/counter reference model.
module tb_fmap_stream_buffer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int F     = 2;
  localparam int AW    = 5;
  localparam int PLANE = W * H;
  localparam int DEPTH = PLANE * F;

  logic          clk;
  logic          rst;
  logic          clear;
  logic [AW:0]   wr_count;
  logic          plane_done;
  logic          full;
  logic          overrun;

  fmap_stream_buffer_if #(.ADDR_W(AW)) bus ();

  fmap_stream_buffer #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .FILTERS (F),
    .ADDR_W  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus),
    .wr_count   (wr_count),
    .plane_done (plane_done),
    .full       (full),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  logic [7:0] model_mem [DEPTH];
  bit         written   [DEPTH];
  int         cnt;
  bit         ovr;
  int         a_q;
  int         n_checks;
  int         n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat8(input logic signed [31:0] d);
    if (d < 0) return 8'd0;
    if (d > 255) return 8'd255;
    return d[7:0];
  endfunction

  // one clock cycle: drive inputs, advance model across the edge, compare after the edge
  task automatic cyc(input bit v, input logic [31:0] d, input int ra, input bit clr);
    bit         rd_ok;
    logic [7:0] exp_rd;
    bit         exp_pd;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_addr  = AW'(ra);
    clear        = clr;
    @(posedge clk);
    rd_ok  = (a_q >= DEPTH) || written[a_q];
    exp_rd = (a_q >= DEPTH) ? 8'd0 : model_mem[a_q];
    a_q    = ra;
    exp_pd = 1'b0;
    if (clr) begin
      cnt = 0;
      ovr = 1'b0;
    end else if (v) begin
      if (cnt == DEPTH) begin
        ovr = 1'b1;
      end else begin
        model_mem[cnt] = sat8(d);
        written[cnt]   = 1'b1;
        cnt++;
        exp_pd = (cnt % PLANE) == 0;
      end
    end
    #1;
    check("wr_count", 32'(wr_count), 32'(cnt));
    check("full", 32'(full), 32'(cnt == DEPTH));
    check("overrun", 32'(overrun), 32'(ovr));
    check("plane_done", 32'(plane_done), 32'(exp_pd));
    if (rd_ok) check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
  endtask

  // reset pulse asserted between edges; outputs must clear without a clock
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_plane_done", 32'(plane_done), 0);
    check("rst_full", 32'(full), 0);
    check("rst_overrun", 32'(overrun), 0);
    cnt = 0;
    ovr = 1'b0;
    a_q = 0;
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] edge_vals [6];
  logic [7:0]  sat_exp   [4];

  initial begin
    edge_vals[0] = 32'd0;          edge_vals[1] = 32'd255;
    edge_vals[2] = 32'd256;        edge_vals[3] = 32'hFFFF_FFFF;
    edge_vals[4] = 32'h7FFF_FFFF;  edge_vals[5] = 32'h8000_0000;
    sat_exp[0] = 8'd0; sat_exp[1] = 8'd255; sat_exp[2] = 8'd255; sat_exp[3] = 8'd0;
    n_checks = 0;
    n_errors = 0;
    cnt = 0;
    ovr = 1'b0;
    a_q = 0;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wr_count", 32'(wr_count), 0);
    check("reset_full", 32'(full), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_plane_done", 32'(plane_done), 0);
    check("reset_rd_data", 32'(bus.rd_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // T1: fill 0..15 with random idle gaps
    for (int i = 0; i < DEPTH; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) cyc(1'b0, 32'd0, int'($urandom_range(0, 31)), 1'b0);
      cyc(1'b1, 32'(i), int'($urandom_range(0, 31)), 1'b0);
    end
    check("t1_full", 32'(full), 1);
    check("t1_count", 32'(wr_count), 16);
    cyc(1'b0, 0, 9, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    check("t1_rd9", 32'(bus.rd_data), 9);

    // T4: back-to-back reads, then an out-of-range address
    cyc(1'b0, 0, 3, 1'b0);
    cyc(1'b0, 0, 4, 1'b0);
    check("t4_rd3", 32'(bus.rd_data), 3);
    cyc(1'b0, 0, 5, 1'b0);
    check("t4_rd4", 32'(bus.rd_data), 4);
    cyc(1'b0, 0, 20, 1'b0);
    check("t4_rd5", 32'(bus.rd_data), 5);
    cyc(1'b0, 0, 0, 1'b0);
    check("t4_rd20", 32'(bus.rd_data), 0);

    // T3: overrun while full, then clear beats a same-cycle sample
    cyc(1'b1, 32'd77, 15, 1'b0);
    check("t3_overrun", 32'(overrun), 1);
    check("t3_count", 32'(wr_count), 16);
    cyc(1'b0, 0, 15, 1'b0);
    cyc(1'b1, 32'd99, 0, 1'b1);
    check("t3_clr_overrun", 32'(overrun), 0);
    check("t3_clr_full", 32'(full), 0);
    check("t3_clr_count", 32'(wr_count), 0);

    // T2: saturation into addresses 0..3
    cyc(1'b1, -32'sd5, 0, 1'b0);
    cyc(1'b1, 32'd300, 0, 1'b0);
    cyc(1'b1, 32'd255, 0, 1'b0);
    cyc(1'b1, 32'h8000_0000, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 0, i % 4, 1'b0);
      check("t2_sat", 32'(bus.rd_data), 32'(sat_exp[i-1]));
    end

    // T5: write 42 to addr 5 on the same edge the read of addr 5 resolves
    cyc(1'b1, 32'd4, 5, 1'b0);
    cyc(1'b1, 32'd42, 5, 1'b0);
    check("t5_old", 32'(bus.rd_data), 5);
    cyc(1'b0, 0, 5, 1'b0);
    check("t5_new", 32'(bus.rd_data), 42);

    // T6: async reset mid-fill, refill from address 0
    check("t6_pre_count", 32'(wr_count), 6);
    async_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(100 + i), 0, 1'b0);
    cyc(1'b0, 0, 1, 1'b0);
    cyc(1'b0, 0, 5, 1'b0);
    check("t6_rd1", 32'(bus.rd_data), 101);
    cyc(1'b0, 0, 0, 1'b0);
    check("t6_rd5_kept", 32'(bus.rd_data), 42);

    // randomized phase
    for (int n = 0; n < 800; n++) begin
      logic [31:0] d;
      int          sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       d = 32'($urandom_range(0, 255));
        1:       d = -32'($urandom_range(1, 1000));
        2:       d = $urandom;
        default: d = edge_vals[$urandom_range(0, 5)];
      endcase
      if ($urandom_range(0, 199) == 0)
        async_reset();
      else
        cyc($urandom_range(0, 9) < 6, d, int'($urandom_range(0, 31)),
            $urandom_range(0, 59) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
